mult_div_unit: RTL and testbench

//  Multi-cycle multiply/divide unit for the EX stage. Sits beside the ALU and owns HI/LO.

---
 rtl/mult_div_unit.sv | 185 ++++++++++++++++++
 tb/tb_mult_div_unit.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mult_div_unit.sv
// mult_div_unit
//   Multi-cycle multiply/divide unit for the EX stage; owns the HI/LO registers.
//   Decodes R-type Funct codes mult/multu/div/divu/mthi/mtlo. Signed when Funct[0]==0.
//   Iterative shift-add multiplier and restoring divider working on operand magnitudes,
//   with a sign fixup cycle before HI/LO are written. FAST_MUL=1 computes the product
//   combinationally at accept time and goes straight to the fixup cycle.
// Ports
//   clk      in   rising-edge clock
//   reset_n  in   asynchronous active-low reset
//   start    in   request valid, sampled only while idle
//   Funct    in   [5:0] operation select
//   A, B     in   [WIDTH-1:0] rs / rt operands
//   abort    in   pipeline flush; cancels an in-flight op, suppresses a same-cycle start
//   busy     out  high while an operation is in flight
//   done     out  one-cycle pulse after HI/LO written by mult/div
//   hi, lo   out  [WIDTH-1:0] HI / LO registers
module mult_div_unit #(
    parameter int unsigned WIDTH    = 32,
    parameter bit          FAST_MUL = 1'b0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [5:0]       Funct,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             abort,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int unsigned CW = $clog2(WIDTH) + 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;

    localparam logic [5:0] F_MULT  = 6'h18;
    localparam logic [5:0] F_MULTU = 6'h19;
    localparam logic [5:0] F_DIV   = 6'h1A;
    localparam logic [5:0] F_DIVU  = 6'h1B;
    localparam logic [5:0] F_MTHI  = 6'h11;
    localparam logic [5:0] F_MTLO  = 6'h13;

    logic [1:0]       state;
    logic [CW-1:0]    cnt;
    // acc: product upper half / partial remainder.
    // qr : multiplier shifting out / dividend shifting out, quotient shifting in.
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] qr;
    logic [WIDTH-1:0] mb;      // multiplicand or divisor magnitude
    logic [WIDTH-1:0] a_raw;   // original dividend, returned in HI on divide by zero
    logic             op_div;
    logic             neg_p;   // negate product / quotient
    logic             neg_r;   // negate remainder
    logic             div0;

    // Request decode
    logic             is_mul, is_div, is_sgn, a_neg, b_neg;
    logic [WIDTH-1:0] a_mag, b_mag;
    logic [2*WIDTH-1:0] fast_prod;

    always_comb begin
        is_mul    = (Funct == F_MULT) || (Funct == F_MULTU);
        is_div    = (Funct == F_DIV)  || (Funct == F_DIVU);
        is_sgn    = ~Funct[0];
        a_neg     = is_sgn & A[WIDTH-1];
        b_neg     = is_sgn & B[WIDTH-1];
        a_mag     = a_neg ? -A : A;
        b_mag     = b_neg ? -B : B;
        fast_prod = {{WIDTH{1'b0}}, a_mag} * {{WIDTH{1'b0}}, b_mag};
    end

    // One iteration of either datapath
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   div_sh;
    logic [WIDTH:0]   div_diff;
    logic             div_ge;

    always_comb begin
        mul_sum  = {1'b0, acc} + (qr[0] ? {1'b0, mb} : '0);
        div_sh   = {acc, qr[WIDTH-1]};
        div_diff = div_sh - {1'b0, mb};
        div_ge   = (div_sh >= {1'b0, mb});
    end

    // Sign fixup of the finished magnitudes
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   q_fix, r_fix;

    always_comb begin
        prod_fix = neg_p ? -{acc, qr} : {acc, qr};
        q_fix    = neg_p ? -qr  : qr;
        r_fix    = neg_r ? -acc : acc;
    end

    assign busy = (state != S_IDLE);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state  <= S_IDLE;
            cnt    <= '0;
            acc    <= '0;
            qr     <= '0;
            mb     <= '0;
            a_raw  <= '0;
            op_div <= 1'b0;
            neg_p  <= 1'b0;
            neg_r  <= 1'b0;
            div0   <= 1'b0;
            done   <= 1'b0;
            hi     <= '0;
            lo     <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start && !abort) begin
                        if (is_mul || is_div) begin
                            a_raw  <= A;
                            op_div <= is_div;
                            neg_p  <= a_neg ^ b_neg;
                            neg_r  <= a_neg;
                            div0   <= is_div && (B == '0);
                            cnt    <= '0;
                            if (FAST_MUL && is_mul) begin
                                {acc, qr} <= fast_prod;
                                mb        <= a_mag;
                                state     <= S_FIX;
                            end else begin
                                acc   <= '0;
                                mb    <= is_mul ? a_mag : b_mag;
                                qr    <= is_mul ? b_mag : a_mag;
                                state <= S_RUN;
                            end
                        end else if (Funct == F_MTHI) begin
                            hi <= A;
                        end else if (Funct == F_MTLO) begin
                            lo <= A;
                        end
                    end
                end
                S_RUN: begin
                    if (abort) begin
                        state <= S_IDLE;
                    end else begin
                        if (op_div) begin
                            acc <= div_ge ? div_diff[WIDTH-1:0] : div_sh[WIDTH-1:0];
                            qr  <= {qr[WIDTH-2:0], div_ge};
                        end else begin
                            // Shift the sum's LSB down into the product's lower half.
                            acc <= mul_sum[WIDTH:1];
                            qr  <= {mul_sum[0], qr[WIDTH-1:1]};
                        end
                        cnt <= cnt + 1'b1;
                        if (cnt == CW'(WIDTH - 1)) begin
                            state <= S_FIX;
                        end
                    end
                end
                S_FIX: begin
                    state <= S_IDLE;
                    if (!abort) begin
                        done <= 1'b1;
                        if (!op_div) begin
                            hi <= prod_fix[2*WIDTH-1:WIDTH];
                            lo <= prod_fix[WIDTH-1:0];
                        end else if (div0) begin
                            hi <= a_raw;
                            lo <= '1;
                        end else begin
                            // MIN/-1 wraps naturally: magnitude 2^(W-1) negated is MIN.
                            hi <= r_fix;
                            lo <= q_fix;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mult_div_unit.sv
// tb_mult_div_unit
//   Self-checking bench for mult_div_unit: one iterative instance (FAST_MUL=0) and one
//   single-cycle-multiply instance (FAST_MUL=1). Expected HI/LO are pushed into a
//   scoreboard when an op is issued and compared when done pulses.
module tb_mult_div_unit;

    localparam int W = 32;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    logic         s_start = 1'b0, s_abort = 1'b0;
    logic [5:0]   s_funct = '0;
    logic [W-1:0] s_a = '0, s_b = '0;
    logic         s_busy, s_done;
    logic [W-1:0] s_hi, s_lo;

    logic         f_start = 1'b0, f_abort = 1'b0;
    logic [5:0]   f_funct = '0;
    logic [W-1:0] f_a = '0, f_b = '0;
    logic         f_busy, f_done;
    logic [W-1:0] f_hi, f_lo;

    mult_div_unit #(.WIDTH(W), .FAST_MUL(1'b0)) u_slow (
        .clk(clk), .reset_n(reset_n), .start(s_start), .Funct(s_funct),
        .A(s_a), .B(s_b), .abort(s_abort), .busy(s_busy), .done(s_done),
        .hi(s_hi), .lo(s_lo)
    );

    mult_div_unit #(.WIDTH(W), .FAST_MUL(1'b1)) u_fast (
        .clk(clk), .reset_n(reset_n), .start(f_start), .Funct(f_funct),
        .A(f_a), .B(f_b), .abort(f_abort), .busy(f_busy), .done(f_done),
        .hi(f_hi), .lo(f_lo)
    );

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        string        tag;
    } exp_t;

    exp_t sb[$];
    exp_t cur;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference: full-width signed/unsigned arithmetic, with the unit's div-by-zero rule.
    function automatic void model(input logic [5:0] f, input logic [W-1:0] a,
                                  input logic [W-1:0] b,
                                  output logic [W-1:0] h, output logic [W-1:0] l);
        longint      p, q, r;
        logic [63:0] u;
        h = '0;
        l = '0;
        case (f)
            6'h18: begin
                p = longint'($signed(a)) * longint'($signed(b));
                u = p;
                h = u[63:32];
                l = u[31:0];
            end
            6'h19: begin
                u = {32'b0, a} * {32'b0, b};
                h = u[63:32];
                l = u[31:0];
            end
            6'h1A: begin
                if (b == '0) begin
                    h = a;
                    l = '1;
                end else begin
                    q = longint'($signed(a)) / longint'($signed(b));
                    r = longint'($signed(a)) % longint'($signed(b));
                    l = q[31:0];
                    h = r[31:0];
                end
            end
            6'h1B: begin
                if (b == '0) begin
                    h = a;
                    l = '1;
                end else begin
                    l = a / b;
                    h = a % b;
                end
            end
            default: ;
        endcase
    endfunction

    // Scoreboard consumer
    always @(negedge clk) begin
        if (s_done || f_done) begin
            if (sb.size() == 0) begin
                check("unexpected_done", 64'd1, 64'd0);
            end else begin
                cur = sb.pop_front();
                check({cur.tag, "_hi"}, {32'b0, s_done ? s_hi : f_hi}, {32'b0, cur.hi});
                check({cur.tag, "_lo"}, {32'b0, s_done ? s_lo : f_lo}, {32'b0, cur.lo});
            end
        end
    end

    // Drive a one-cycle request; returns at the negedge after the accepting edge.
    task automatic issue(input bit fast, input bit push, input logic [5:0] f,
                         input logic [W-1:0] a, input logic [W-1:0] b, input string tag);
        exp_t e;
        if (push) begin
            model(f, a, b, e.hi, e.lo);
            e.tag = tag;
            sb.push_back(e);
        end
        @(negedge clk);
        if (fast) begin
            f_start = 1'b1; f_funct = f; f_a = a; f_b = b;
        end else begin
            s_start = 1'b1; s_funct = f; s_a = a; s_b = b;
        end
        @(negedge clk);
        s_start = 1'b0;
        f_start = 1'b0;
    endtask

    // Count busy samples until done; check latency and one-cycle done pulse.
    task automatic wait_done(input bit fast, input string tag, input int exp_busy);
        int  n = 0;
        bit  seen = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (fast ? f_done : s_done) begin
                seen = 1'b1;
                break;
            end
            if (fast ? f_busy : s_busy) n++;
            @(negedge clk);
        end
        check({tag, "_done_seen"}, {63'b0, seen}, 64'd1);
        check({tag, "_busy_cycles"}, 64'(n), 64'(exp_busy));
        @(negedge clk);
        check({tag, "_done_pulse"}, {63'b0, fast ? f_done : s_done}, 64'd0);
    endtask

    task automatic run_op(input bit fast, input logic [5:0] f, input logic [W-1:0] a,
                          input logic [W-1:0] b, input string tag);
        issue(fast, 1'b1, f, a, b, tag);
        wait_done(fast, tag, fast && (f == 6'h18 || f == 6'h19) ? 1 : W + 1);
    endtask

    logic [5:0]   flist [4] = '{6'h18, 6'h19, 6'h1A, 6'h1B};
    logic [W-1:0] old_hi, old_lo, rb;
    int           dcnt;

    initial begin
        #12;
        check("rst_busy", {63'b0, s_busy}, 64'd0);
        check("rst_done", {63'b0, s_done}, 64'd0);
        check("rst_hi", {32'b0, s_hi}, 64'd0);
        check("rst_lo", {32'b0, s_lo}, 64'd0);
        @(negedge clk);
        reset_n = 1'b1;

        run_op(1'b0, 6'h18, -32'sd3, 32'sd5, "mult_m3x5");
        run_op(1'b0, 6'h19, 32'hFFFFFFFF, 32'hFFFFFFFF, "multu_max");
        run_op(1'b1, 6'h19, 32'hFFFFFFFF, 32'hFFFFFFFF, "fast_multu_max");
        run_op(1'b1, 6'h18, -32'sd3, 32'sd5, "fast_mult_m3x5");
        run_op(1'b1, 6'h1B, 32'd100, 32'd7, "fast_divu");
        run_op(1'b0, 6'h1A, -32'sd7, 32'sd2, "div_m7d2");
        run_op(1'b0, 6'h1A, 32'sd7, -32'sd2, "div_7dm2");
        run_op(1'b0, 6'h1A, 32'h80000000, 32'hFFFFFFFF, "div_ovf");
        run_op(1'b0, 6'h1B, 32'd7, 32'd0, "divu_by0");
        run_op(1'b0, 6'h1A, -32'sd7, 32'd0, "div_by0");
        run_op(1'b0, 6'h1B, 32'hFFFFFFFF, 32'd3, "divu_max");
        run_op(1'b0, 6'h18, 32'h80000000, 32'h80000000, "mult_min");

        for (int i = 0; i < 6; i++) begin
            rb = (i % 3 == 0) ? 32'($urandom_range(0, 3)) : 32'($urandom);
            run_op(1'b0, flist[i % 4], 32'($urandom), rb, "rand");
        end

        // mthi in idle: visible after the next edge, no done
        @(negedge clk);
        s_start = 1'b1; s_funct = 6'h11; s_a = 32'h1234;
        @(negedge clk);
        s_start = 1'b0;
        check("mthi_hi", {32'b0, s_hi}, 64'h1234);
        check("mthi_busy", {63'b0, s_busy}, 64'd0);
        check("mthi_done", {63'b0, s_done}, 64'd0);

        // mtlo while busy is ignored
        old_lo = s_lo;
        issue(1'b0, 1'b1, 6'h1B, 32'd100, 32'd7, "divu_mtlo");
        repeat (5) @(negedge clk);
        s_start = 1'b1; s_funct = 6'h13; s_a = 32'hABCD0000;
        @(negedge clk);
        s_start = 1'b0;
        check("mtlo_busy_lo", {32'b0, s_lo}, {32'b0, old_lo});
        wait_done(1'b0, "divu_mtlo", W + 1 - 6);

        // abort in RUN: back to idle, HI/LO untouched, no done
        old_hi = s_hi;
        old_lo = s_lo;
        issue(1'b0, 1'b0, 6'h18, 32'd9, 32'd9, "abort_mult");
        repeat (10) @(negedge clk);
        s_abort = 1'b1;
        @(negedge clk);
        s_abort = 1'b0;
        check("abort_busy", {63'b0, s_busy}, 64'd0);
        check("abort_hi", {32'b0, s_hi}, {32'b0, old_hi});
        check("abort_lo", {32'b0, s_lo}, {32'b0, old_lo});
        dcnt = 0;
        for (int i = 0; i < 40; i++) begin
            if (s_done) dcnt++;
            @(negedge clk);
        end
        check("abort_no_done", 64'(dcnt), 64'd0);

        // abort in idle suppresses a same-cycle mthi
        @(negedge clk);
        s_start = 1'b1; s_funct = 6'h11; s_a = 32'hDEADBEEF; s_abort = 1'b1;
        @(negedge clk);
        s_start = 1'b0; s_abort = 1'b0;
        check("abort_idle_hi", {32'b0, s_hi}, {32'b0, old_hi});
        check("abort_idle_busy", {63'b0, s_busy}, 64'd0);

        // abort in FIX: no write, no done
        issue(1'b1, 1'b0, 6'h18, 32'd3, 32'd3, "abort_fix");
        old_hi = f_hi;
        old_lo = f_lo;
        f_abort = 1'b1;
        @(negedge clk);
        f_abort = 1'b0;
        check("abort_fix_busy", {63'b0, f_busy}, 64'd0);
        check("abort_fix_done", {63'b0, f_done}, 64'd0);
        check("abort_fix_lo", {32'b0, f_lo}, {32'b0, old_lo});

        // asynchronous reset mid-RUN
        check("pre_reset_hi_nonzero", {63'b0, s_hi != '0}, 64'd1);
        issue(1'b0, 1'b0, 6'h1A, 32'd1000, 32'd3, "reset_div");
        repeat (8) @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        check("midrst_busy", {63'b0, s_busy}, 64'd0);
        check("midrst_done", {63'b0, s_done}, 64'd0);
        check("midrst_hi", {32'b0, s_hi}, 64'd0);
        check("midrst_lo", {32'b0, s_lo}, 64'd0);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (40) @(negedge clk);
        check("midrst_idle", {63'b0, s_busy}, 64'd0);
        check("sb_empty", 64'(sb.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
